binary_search_ctrl: RTL and testbench
=====================================

BINARY_SEARCH_CTRL -- requirements
Module: binary_search_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the guess width; legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: begin a search when idle or done.
REQ-005 The block SHALL have ports eq, lt and gt, each an input of 1 bit: comparison of guess against the secret value (lt means guess < secret).
REQ-006 The block SHALL have port guess, output, WIDTH bits: the current probe value, registered.
REQ-007 The block SHALL have port busy, output, 1 bit: high while searching.
REQ-008 The block SHALL have port done, output, 1 bit: high while the result is held.
REQ-009 The block SHALL have port found, output, 1 bit: the result hit (valid while done=1).
REQ-010 The block SHALL have port err, output, 1 bit: illegal comparator flags were seen (valid while done=1).
REQ-011 The block SHALL have port steps, output, WIDTH bits: the number of probes evaluated in the current or last search.

Function
REQ-012 The FSM SHALL have states IDLE, PROBE and DONE.
REQ-013 The block SHALL keep internal bounds lo and hi, each WIDTH bits; MAX = 2^WIDTH-1.
REQ-014 In IDLE or DONE, start=1 SHALL load lo=0, hi=MAX, guess=(0+MAX)>>1, steps=0, found=0 and err=0, and move to PROBE on the next edge.
REQ-015 In PROBE, eq/lt/gt SHALL be sampled every cycle; the comparator is combinational and external, so there is no wait state.
REQ-016 Every PROBE cycle SHALL increment steps by 1.
REQ-017 On eq=1 in PROBE, the block SHALL set found=1 and move to DONE; guess SHALL hold the matched value.
REQ-018 On lt=1 in PROBE: if guess==MAX, the block SHALL move to DONE with found=0; otherwise lo<=guess+1 and guess<=(guess+1+hi)>>1.
REQ-019 On gt=1 in PROBE: if guess==0, the block SHALL move to DONE with found=0; otherwise hi<=guess-1 and guess<=(lo+guess-1)>>1.
REQ-020 The midpoint sum SHALL be computed in WIDTH+1 bits, so it never wraps.
REQ-021 If an update makes lo>hi, the block SHALL move to DONE with found=0 and guess unchanged.
REQ-022 The worst-case search SHALL take WIDTH+1 PROBE cycles; done SHALL rise one cycle after the deciding sample.
REQ-023 busy SHALL be 1 exactly in PROBE; done SHALL be 1 exactly in DONE.
REQ-024 DONE SHALL hold guess, found, err and steps until start or rst.
REQ-025 start during PROBE SHALL be ignored.
REQ-026 start in DONE SHALL restart the search with the same timing as from IDLE.

Reset
REQ-027 rst=1 SHALL force the FSM to IDLE and set guess=0, lo=0, hi=MAX, steps=0, busy=0, done=0, found=0 and err=0 on the next edge.
REQ-028 rst SHALL take priority over start, including when asserted during PROBE.
REQ-029 A search aborted by rst SHALL leave no residue in the outputs.

Configuration
REQ-030 The macro BSEARCH_FLAG_CHECK_EN SHALL control illegal-flag checking.
REQ-031 With BSEARCH_FLAG_CHECK_EN defined, a PROBE sample where eq+lt+gt != 1 SHALL set err=1 and found=0 and move to DONE, and steps SHALL still increment.
REQ-032 Without BSEARCH_FLAG_CHECK_EN, err SHALL be constant 0; flag priority SHALL be eq > gt > lt, and all flags low SHALL be treated as lt.

Verification (bench drives eq/lt/gt from a behavioural comparator against a secret, WIDTH=4)
REQ-033 Secret=12, start pulse -> guesses 7, 11, 13, 12; done=1 with found=1, guess=12, steps=4.
REQ-034 Secret=15 -> guesses 7, 11, 13, 14, 15; found=1, steps=5 (worst case).
REQ-035 Secret=0 -> guesses 7, 3, 1, 0; found=1, steps=4; no underflow.
REQ-036 Comparator forced to lt=1 constantly -> guess reaches 15, then done with found=0 and steps=5.
REQ-037 rst asserted on the 2nd PROBE cycle -> next cycle IDLE with all outputs 0; a following start with secret=5 gives found=1, guess=5.
REQ-038 With BSEARCH_FLAG_CHECK_EN, lt=gt=1 on the first probe -> done=1, err=1, found=0, steps=1; without the macro, the same stimulus is treated as gt and the search continues with guess=3.

Source files
------------

// File: rtl/binary_search_ctrl.sv
// Binary search controller: drives a probe value against an external
// combinational comparator and narrows [lo, hi] until it hits or runs out.
// Optional feature macro: BSEARCH_FLAG_CHECK_EN. When defined, any probe
// cycle that does not see exactly one of eq/lt/gt aborts the search with err.
// When undefined, err is tied low and flags resolve as eq > gt > lt, with no
// flags set treated as lt.
module binary_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] steps
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             found_q, found_d;

  logic [WIDTH-1:0] newLo, newHi;
  logic [WIDTH:0]   sumUp, sumDown;
  logic             goUp;

`ifdef BSEARCH_FLAG_CHECK_EN
  logic             err_q, err_d;
  logic             flagsBad;
  assign flagsBad = (({1'b0, eq} + {1'b0, lt} + {1'b0, gt}) != 2'd1);
`endif

  // Candidate bounds and midpoints; sums are one bit wider so they never wrap
  assign newLo   = guess_q + ONE;
  assign newHi   = guess_q - ONE;
  assign sumUp   = {1'b0, newLo} + {1'b0, hi_q};
  assign sumDown = {1'b0, lo_q} + {1'b0, newHi};
  assign goUp    = lt | ~gt;

  // Next-state logic: load on start, narrow the interval on each probe
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    steps_d = steps_q;
    found_d = found_q;
`ifdef BSEARCH_FLAG_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lo_d    = ZERO;
          hi_d    = MAX;
          guess_d = MAX >> 1;
          steps_d = ZERO;
          found_d = 1'b0;
`ifdef BSEARCH_FLAG_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = PROBE;
        end
      end
      PROBE: begin
        steps_d = steps_q + ONE;
`ifdef BSEARCH_FLAG_CHECK_EN
        if (flagsBad) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = DONE;
        end else
`endif
        if (eq) begin
          found_d = 1'b1;
          state_d = DONE;
        end else if (gt) begin
          if (guess_q == ZERO || lo_q > newHi) begin
            state_d = DONE;
          end else begin
            hi_d    = newHi;
            guess_d = sumDown[WIDTH:1];
          end
        end else if (goUp) begin
          if (guess_q == MAX || newLo > hi_q) begin
            state_d = DONE;
          end else begin
            lo_d    = newLo;
            guess_d = sumUp[WIDTH:1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that clears every trace of a search
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= ZERO;
      hi_q    <= MAX;
      guess_q <= ZERO;
      steps_q <= ZERO;
      found_q <= 1'b0;
`ifdef BSEARCH_FLAG_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      steps_q <= steps_d;
      found_q <= found_d;
`ifdef BSEARCH_FLAG_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign guess = guess_q;
  assign steps = steps_q;
  assign found = found_q;
  assign busy  = (state_q == PROBE);
  assign done  = (state_q == DONE);
`ifdef BSEARCH_FLAG_CHECK_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Self-checking bench for binary_search_ctrl (WIDTH=4) with a behavioural
// comparator and a high-level search reference model.
module tb_binary_search_ctrl;

  localparam int WIDTH = 4;
  localparam int MAX   = 15;

  logic             clk = 1'b0;
  logic             rst, start, eq, lt, gt;
  logic [WIDTH-1:0] guess, steps;
  logic             busy, done, found, err;

  int nChecks = 0;
  int nFail   = 0;

  int secret  = 0;
  int cmpMode = 0;   // 0: true comparator, 1: always lt, 2: lt and gt both set

  int obsGuess [0:63];
  int expGuess [$];
  int expFound, expErr, expSteps, expFinal;

  binary_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .eq(eq), .lt(lt), .gt(gt),
    .guess(guess), .busy(busy), .done(done), .found(found), .err(err),
    .steps(steps)
  );

  always #5 clk = ~clk;

  // Behavioural comparator: relation of the current probe to the secret
  always_comb begin
    eq = 1'b0; lt = 1'b0; gt = 1'b0;
    case (cmpMode)
      0: begin
        eq = (int'(guess) == secret);
        lt = (int'(guess) <  secret);
        gt = (int'(guess) >  secret);
      end
      1: lt = 1'b1;
      default: begin lt = 1'b1; gt = 1'b1; end
    endcase
  end

  // Reference: classic integer binary search over [0, MAX]
  task automatic modelSearch(input int sec, input int mode);
    int lo, hi, g;
    bit goDown;
    lo = 0; hi = MAX; g = MAX / 2;
    expGuess.delete(); expFound = 0; expErr = 0;
    while (expGuess.size() < 20) begin
      expGuess.push_back(g);
      if (mode == 2) begin
`ifdef BSEARCH_FLAG_CHECK_EN
        expErr = 1;
        break;
`else
        goDown = 1;
`endif
      end else if (mode == 1) begin
        goDown = 0;
      end else begin
        if (g == sec) begin expFound = 1; break; end
        goDown = (g > sec);
      end
      if (goDown) begin
        if (g == 0 || lo > g - 1) break;
        hi = g - 1;
      end else begin
        if (g == MAX || g + 1 > hi) break;
        lo = g + 1;
      end
      g = (lo + hi) / 2;
    end
    expSteps = expGuess.size();
    expFinal = expGuess[expGuess.size() - 1];
  endtask

  // Start a search and record every probe value until done (bounded)
  task automatic runSearch(input int glitchAt, output int nObs, output bit timedOut);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nObs = 0; timedOut = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin timedOut = 1'b0; break; end
      if (busy === 1'b1 && nObs < 64) begin obsGuess[nObs] = int'(guess); nObs++; end
      start = (c == glitchAt);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++; if (guess !== 4'd0) begin nFail++; $display("[TB] FAIL reset_guess got %0d want 0", guess); end
    nChecks++; if (steps !== 4'd0) begin nFail++; $display("[TB] FAIL reset_steps got %0d want 0", steps); end
    nChecks++; if (busy  !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    nChecks++; if (done  !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    nChecks++; if (found !== 1'b0) begin nFail++; $display("[TB] FAIL reset_found got %b want 0", found); end
    nChecks++; if (err   !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int secs [3] = '{12, 15, 0};
    int lits [3] = '{4, 5, 4};
    int n; bit to;
    foreach (secs[k]) begin
      secret = secs[k]; cmpMode = 0;
      modelSearch(secret, 0);
      runSearch(-1, n, to);
      nChecks++; if (to) begin nFail++; $display("[TB] FAIL dir_timeout secret=%0d got no done want done", secret); end
      nChecks++; if (n != expSteps) begin nFail++; $display("[TB] FAIL dir_probes secret=%0d got %0d want %0d", secret, n, expSteps); end
      for (int i = 0; i < n && i < expSteps; i++) begin
        nChecks++;
        if (obsGuess[i] != expGuess[i]) begin nFail++; $display("[TB] FAIL dir_seq[%0d] secret=%0d got %0d want %0d", i, secret, obsGuess[i], expGuess[i]); end
      end
      nChecks++; if (found !== 1'b1) begin nFail++; $display("[TB] FAIL dir_found secret=%0d got %b want 1", secret, found); end
      nChecks++; if (int'(guess) != secret) begin nFail++; $display("[TB] FAIL dir_guess got %0d want %0d", guess, secret); end
      nChecks++; if (int'(steps) != lits[k]) begin nFail++; $display("[TB] FAIL dir_steps secret=%0d got %0d want %0d", secret, steps, lits[k]); end
      nChecks++; if (busy !== 1'b0 || err !== 1'b0) begin nFail++; $display("[TB] FAIL dir_busy_err got %b%b want 00", busy, err); end
    end
  endtask

  task automatic test_always_lt;
    int n; bit to;
    cmpMode = 1;
    modelSearch(0, 1);
    runSearch(-1, n, to);
    nChecks++; if (to) begin nFail++; $display("[TB] FAIL lt_timeout got no done want done"); end
    nChecks++; if (n != expSteps) begin nFail++; $display("[TB] FAIL lt_probes got %0d want %0d", n, expSteps); end
    nChecks++; if (found !== 1'b0) begin nFail++; $display("[TB] FAIL lt_found got %b want 0", found); end
    nChecks++; if (guess !== 4'd15) begin nFail++; $display("[TB] FAIL lt_guess got %0d want 15", guess); end
    nChecks++; if (steps !== 4'd5) begin nFail++; $display("[TB] FAIL lt_steps got %0d want 5", steps); end
    cmpMode = 0;
  endtask

  task automatic test_flags;
    int n; bit to;
    cmpMode = 2;
    modelSearch(0, 2);
    runSearch(-1, n, to);
    nChecks++; if (to) begin nFail++; $display("[TB] FAIL flag_timeout got no done want done"); end
    nChecks++; if (int'(steps) != expSteps) begin nFail++; $display("[TB] FAIL flag_steps got %0d want %0d", steps, expSteps); end
    nChecks++; if (int'(err) != expErr) begin nFail++; $display("[TB] FAIL flag_err got %b want %0d", err, expErr); end
    nChecks++; if (found !== 1'b0) begin nFail++; $display("[TB] FAIL flag_found got %b want 0", found); end
    nChecks++; if (int'(guess) != expFinal) begin nFail++; $display("[TB] FAIL flag_guess got %0d want %0d", guess, expFinal); end
`ifndef BSEARCH_FLAG_CHECK_EN
    nChecks++; if (n < 2 || obsGuess[1] != 3) begin nFail++; $display("[TB] FAIL flag_second_probe got %0d want 3", (n < 2) ? -1 : obsGuess[1]); end
`endif
    cmpMode = 0;
  endtask

  task automatic test_start_in_probe;
    int n; bit to;
    secret = 12; cmpMode = 0;
    modelSearch(secret, 0);
    runSearch(1, n, to);
    nChecks++; if (to) begin nFail++; $display("[TB] FAIL sip_timeout got no done want done"); end
    nChecks++; if (n != expSteps) begin nFail++; $display("[TB] FAIL sip_probes got %0d want %0d", n, expSteps); end
    for (int i = 0; i < n && i < expSteps; i++) begin
      nChecks++;
      if (obsGuess[i] != expGuess[i]) begin nFail++; $display("[TB] FAIL sip_seq[%0d] got %0d want %0d", i, obsGuess[i], expGuess[i]); end
    end
    nChecks++; if (steps !== 4'd4 || found !== 1'b1) begin nFail++; $display("[TB] FAIL sip_result got steps=%0d found=%b want steps=4 found=1", steps, found); end
  endtask

  task automatic test_hold;
    logic [WIDTH-1:0] g0, s0;
    logic f0;
    g0 = guess; s0 = steps; f0 = found;
    repeat (5) @(negedge clk);
    nChecks++; if (done !== 1'b1) begin nFail++; $display("[TB] FAIL hold_done got %b want 1", done); end
    nChecks++; if (guess !== 4'd12 || steps !== 4'd4 || found !== 1'b1) begin nFail++; $display("[TB] FAIL hold_values got g=%0d s=%0d f=%b want g=12 s=4 f=1 (was %0d %0d %b)", guess, steps, found, g0, s0, f0); end
  endtask

  task automatic test_rst_abort;
    int n; bit to;
    secret = 9; cmpMode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    nChecks++; if ({busy, done, found, err} !== 4'b0000) begin nFail++; $display("[TB] FAIL abort_flags got %b want 0000", {busy, done, found, err}); end
    nChecks++; if (guess !== 4'd0 || steps !== 4'd0) begin nFail++; $display("[TB] FAIL abort_regs got g=%0d s=%0d want 0 0", guess, steps); end
    rst = 1'b0;
    secret = 5;
    modelSearch(secret, 0);
    runSearch(-1, n, to);
    nChecks++; if (to) begin nFail++; $display("[TB] FAIL abort_timeout got no done want done"); end
    nChecks++; if (found !== 1'b1 || guess !== 4'd5) begin nFail++; $display("[TB] FAIL abort_resume got f=%b g=%0d want f=1 g=5", found, guess); end
    nChecks++; if (int'(steps) != expSteps) begin nFail++; $display("[TB] FAIL abort_steps got %0d want %0d", steps, expSteps); end
  endtask

  task automatic test_back_to_back;
    int n; bit to;
    cmpMode = 0;
    for (int r = 0; r < 20; r++) begin
      secret = $urandom_range(MAX, 0);
      modelSearch(secret, 0);
      runSearch(-1, n, to);
      nChecks++;
      if (to || n != expSteps || int'(steps) != expSteps || int'(found) != expFound || int'(guess) != expFinal || err !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL b2b secret=%0d got to=%0d n=%0d steps=%0d found=%b guess=%0d err=%b want steps=%0d found=%0d guess=%0d err=0",
                 secret, to, n, steps, found, guess, err, expSteps, expFound, expFinal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_always_lt();
    test_flags();
    test_start_in_probe();
    test_hold();
    test_rst_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
